// File: rtl/iis_pkg.sv
// Shared sample types for the I2S serialiser/deserialiser.
// Default word width; the top may override its own DATA_W parameter.
package iis_pkg;

    localparam int DATA_W_DEF = 32;

    typedef logic signed [DATA_W_DEF-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

endpackage

// File: rtl/iis_sck_gen.sv
// I2S master timing: divides clk into sck, counts bits per frame, produces ws.
// Latency: sck/ws registered, sck_fall/f_sync combinational one cycle ahead of the edge they announce.
// Backpressure: none, free-running.
module iis_sck_gen #(
    parameter int SCK_DIV   = 4,
    parameter int FRAME_SCK = 64
) (
    input  logic clk,
    input  logic rst_n,
    output logic sck,
    output logic ws,
    output logic sck_fall,
    output logic f_sync
);
    localparam int DIV_W = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_SCK);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_SCK - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(FRAME_SCK / 2);

    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             sck_q, sck_d;
    logic             ws_q, ws_d;

    // sck and ws are derived from next-state counts so they switch on the same edge as the counters
    always_comb begin
        sck_fall  = (div_q == DIV_LAST);
        f_sync    = sck_fall && (bit_cnt_q == BIT_LAST);
        div_d     = sck_fall ? '0 : div_q + DIV_W'(1);
        bit_cnt_d = bit_cnt_q;
        if (sck_fall) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
        end
        sck_d = (div_d >= DIV_HALF);
        ws_d  = (bit_cnt_d >= BIT_HALF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            bit_cnt_q <= BIT_LAST;
            sck_q     <= 1'b0;
            ws_q      <= 1'b1;
        end else begin
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            sck_q     <= sck_d;
            ws_q      <= ws_d;
        end
    end

    assign sck = sck_q;
    assign ws  = ws_q;

endmodule

// File: rtl/iis_serdes.sv
// Stereo I2S master transmitter plus independent receiver; IIS_LOOPBACK_EN feeds rx from own sck/ws/sd.
// Latency: tx left MSB one sck after ws fall; rx_valid 4 clk after the rx_sck rise carrying the right LSB.
// Backpressure: none; tx_rd strobes once per frame, rx_valid pulses once per received pair.
module iis_serdes
    import iis_pkg::*;
#(
    parameter int SCK_DIV   = 4,
    parameter int FRAME_SCK = 64,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     sck,
    output logic                     ws,
    output logic                     sd,
    input  logic signed [DATA_W-1:0] tx_data_l,
    input  logic signed [DATA_W-1:0] tx_data_r,
    output logic                     tx_rd,
    input  logic                     rx_sck,
    input  logic                     rx_ws,
    input  logic                     rx_sd,
    output logic signed [DATA_W-1:0] rx_data_l,
    output logic signed [DATA_W-1:0] rx_data_r,
    output logic                     rx_valid
);
    localparam int HALF  = FRAME_SCK / 2;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic sck_fall, f_sync;

    iis_sck_gen #(
        .SCK_DIV  (SCK_DIV),
        .FRAME_SCK(FRAME_SCK)
    ) u_sck_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .sck     (sck),
        .ws      (ws),
        .sck_fall(sck_fall),
        .f_sync  (f_sync)
    );

    // Transmitter: a whole frame is held so unused trailing slots of each channel shift out as 0
    logic [FRAME_SCK-1:0] sreg_q, sreg_d;
    logic                 sd_q, sd_d;

    always_comb begin
        sreg_d = sreg_q;
        sd_d   = sd_q;
        if (sck_fall) begin
            sd_d = sreg_q[FRAME_SCK-1];
            if (f_sync) begin
                sreg_d = (FRAME_SCK'($unsigned(tx_data_l)) << (FRAME_SCK - DATA_W))
                       | (FRAME_SCK'($unsigned(tx_data_r)) << (HALF - DATA_W));
            end else begin
                sreg_d = {sreg_q[FRAME_SCK-2:0], 1'b0};
            end
        end
    end

    assign tx_rd = f_sync;
    assign sd    = sd_q;

    // Receiver front end: {sck, ws, sd}
    logic [2:0] pin_in;
`ifdef IIS_LOOPBACK_EN
    logic unused_rx_pins;
    assign unused_rx_pins = ^{rx_sck, rx_ws, rx_sd};
    assign pin_in = {sck, ws, sd};
`else
    assign pin_in = {rx_sck, rx_ws, rx_sd};
`endif

    logic [2:0] sync1_q, sync2_q;
    logic       sck_prev_q, sck_prev_d;
    logic       evt_q, evt_d;
    logic       ws_smp_q, ws_smp_d;
    logic       sd_smp_q, sd_smp_d;

    always_comb begin
        sck_prev_d = sync2_q[2];
        evt_d      = sync2_q[2] && !sck_prev_q;
        ws_smp_d   = sync2_q[1];
        sd_smp_d   = sync2_q[0];
    end

    logic              prev_ws_q, prev_ws_d;
    logic              started_q, started_d;
    logic              left_ok_q, left_ok_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] word_q, word_d, word_nxt;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] rx_l_q, rx_l_d;
    logic [DATA_W-1:0] rx_r_q, rx_r_d;
    logic              rx_valid_q, rx_valid_d;

    // Bits land left-justified by position, so short words come out zero-padded and excess bits drop
    always_comb begin
        prev_ws_d  = prev_ws_q;
        started_d  = started_q;
        left_ok_d  = left_ok_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        left_d     = left_q;
        rx_l_d     = rx_l_q;
        rx_r_d     = rx_r_q;
        rx_valid_d = 1'b0;
        word_nxt   = word_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(DATA_W - 1 - i)) begin
                word_nxt[i] = sd_smp_q;
            end
        end
        if (evt_q) begin
            if (ws_smp_q != prev_ws_q) begin
                prev_ws_d = ws_smp_q;
                started_d = 1'b1;
                word_d    = '0;
                cnt_d     = '0;
                if (ws_smp_q) begin
                    left_d    = word_nxt;
                    left_ok_d = started_q;
                end else begin
                    left_ok_d = 1'b0;
                    if (left_ok_q) begin
                        rx_l_d     = left_q;
                        rx_r_d     = word_nxt;
                        rx_valid_d = 1'b1;
                    end
                end
            end else begin
                word_d = word_nxt;
                if (cnt_q < CNT_W'(DATA_W)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q     <= '0;
            sd_q       <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sck_prev_q <= 1'b0;
            evt_q      <= 1'b0;
            ws_smp_q   <= 1'b0;
            sd_smp_q   <= 1'b0;
            prev_ws_q  <= 1'b1;
            started_q  <= 1'b0;
            left_ok_q  <= 1'b0;
            cnt_q      <= '0;
            word_q     <= '0;
            left_q     <= '0;
            rx_l_q     <= '0;
            rx_r_q     <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            sreg_q     <= sreg_d;
            sd_q       <= sd_d;
            sync1_q    <= pin_in;
            sync2_q    <= sync1_q;
            sck_prev_q <= sck_prev_d;
            evt_q      <= evt_d;
            ws_smp_q   <= ws_smp_d;
            sd_smp_q   <= sd_smp_d;
            prev_ws_q  <= prev_ws_d;
            started_q  <= started_d;
            left_ok_q  <= left_ok_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            left_q     <= left_d;
            rx_l_q     <= rx_l_d;
            rx_r_q     <= rx_r_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign rx_data_l = rx_l_q;
    assign rx_data_r = rx_r_q;
    assign rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_iis_serdes.sv
// Bench for iis_serdes: reset/timing, loopback through bench wires, random stream, external 16-bit stream, mid-frame reset.
module tb_iis_serdes;
    import iis_pkg::*;

    localparam int SCK_DIV   = 4;
    localparam int FRAME_SCK = 64;
    localparam int DATA_W    = DATA_W_DEF;
    localparam int FRAME_CYC = SCK_DIV * FRAME_SCK;

    logic    clk = 1'b0;
    logic    rst_n = 1'b1;
    logic    sck, ws, sd, tx_rd, rx_valid;
    sample_t tx_data_l = '0;
    sample_t tx_data_r = '0;
    sample_t rx_data_l, rx_data_r;
    logic    ext_mode = 1'b0;
    logic    ext_sck = 1'b0;
    logic    ext_ws = 1'b1;
    logic    ext_sd = 1'b0;
    logic    rx_sck, rx_ws, rx_sd;
    int      cyc = 0;
    int      n_checks = 0;
    int      n_fail = 0;

    assign rx_sck = ext_mode ? ext_sck : sck;
    assign rx_ws  = ext_mode ? ext_ws  : ws;
    assign rx_sd  = ext_mode ? ext_sd  : sd;

    iis_serdes #(.SCK_DIV(SCK_DIV), .FRAME_SCK(FRAME_SCK), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .ws(ws), .sd(sd),
        .tx_data_l(tx_data_l), .tx_data_r(tx_data_r), .tx_rd(tx_rd),
        .rx_sck(rx_sck), .rx_ws(rx_ws), .rx_sd(rx_sd),
        .rx_data_l(rx_data_l), .rx_data_r(rx_data_r), .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck got %b want 0", sck); end
        n_checks++; if (ws !== 1'b1) begin n_fail++; $display("FAIL reset_ws got %b want 1", ws); end
        n_checks++; if (sd !== 1'b0) begin n_fail++; $display("FAIL reset_sd got %b want 0", sd); end
        n_checks++; if (tx_rd !== 1'b0) begin n_fail++; $display("FAIL reset_tx_rd got %b want 0", tx_rd); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        n_checks++; if (rx_data_l !== '0 || rx_data_r !== '0) begin
            n_fail++; $display("FAIL reset_rx_data got %h/%h want 0/0", rx_data_l, rx_data_r);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // first sck_fall lands on the SCK_DIV-th edge after release
        for (int k = 1; k <= SCK_DIV; k++) begin
            @(negedge clk);
            n_checks++; if (tx_rd !== 1'(k == SCK_DIV - 1)) begin
                n_fail++; $display("FAIL first_tx_rd edge %0d got %b want %b", k, tx_rd, k == SCK_DIV - 1);
            end
            n_checks++; if (ws !== 1'(k < SCK_DIV)) begin
                n_fail++; $display("FAIL first_ws edge %0d got %b want %b", k, ws, k < SCK_DIV);
            end
            n_checks++; if (sck !== 1'(k >= SCK_DIV / 2 && k < SCK_DIV)) begin
                n_fail++; $display("FAIL first_sck edge %0d got %b", k, sck);
            end
        end
    endtask

    task automatic test_clock_timing();
        int last_sck = -1, last_ws = -1, last_rd = -1;
        int n_sck = 0, n_ws = 0, n_rd = 0;
        int bad_sck = 0, bad_ws = 0, bad_rd = 0, bad_align = 0;
        logic p_sck = sck, p_ws = ws, p_rd = tx_rd;
        repeat (3 * FRAME_CYC) begin
            @(negedge clk);
            if (sck && !p_sck) begin
                if (last_sck >= 0 && cyc - last_sck != SCK_DIV) bad_sck++;
                last_sck = cyc; n_sck++;
            end
            if (ws != p_ws) begin
                if (last_ws >= 0 && cyc - last_ws != FRAME_CYC / 2) bad_ws++;
                if (!ws && !p_rd) bad_align++;
                last_ws = cyc; n_ws++;
            end
            if (tx_rd && !p_rd) begin
                if (last_rd >= 0 && cyc - last_rd != FRAME_CYC) bad_rd++;
                last_rd = cyc; n_rd++;
            end
            if (tx_rd && p_rd) bad_rd++;
            p_sck = sck; p_ws = ws; p_rd = tx_rd;
        end
        n_checks++; if (bad_sck != 0 || n_sck < 100) begin
            n_fail++; $display("FAIL sck_period bad=%0d rises=%0d want bad=0 rises>=100", bad_sck, n_sck);
        end
        n_checks++; if (bad_ws != 0 || n_ws < 5) begin
            n_fail++; $display("FAIL ws_period bad=%0d toggles=%0d want bad=0 toggles>=5", bad_ws, n_ws);
        end
        n_checks++; if (bad_rd != 0 || n_rd < 2) begin
            n_fail++; $display("FAIL tx_rd_period bad=%0d pulses=%0d want bad=0 pulses>=2", bad_rd, n_rd);
        end
        n_checks++; if (bad_align != 0) begin
            n_fail++; $display("FAIL ws_fall_after_tx_rd misaligned=%0d want 0", bad_align);
        end
    endtask

    task automatic test_loopback_fixed();
        int ntx = 0, nrx_since = 0, nrx = 0, bad_cnt = 0;
        ext_mode = 1'b0;
        tx_data_l = 32'hA5A5_0001;
        tx_data_r = 32'h8000_0000;
        reset_pulse();
        repeat (6 * FRAME_CYC) begin
            @(negedge clk);
            if (rx_valid) begin
                nrx_since++; nrx++;
                n_checks++; if (rx_data_l !== 32'hA5A5_0001 || rx_data_r !== 32'h8000_0000) begin
                    n_fail++; $display("FAIL loopback_data got %h/%h want a5a50001/80000000", rx_data_l, rx_data_r);
                end
            end
            if (tx_rd) begin
                if (nrx_since != ((ntx >= 2) ? 1 : 0)) bad_cnt++;
                ntx++; nrx_since = 0;
            end
        end
        n_checks++; if (bad_cnt != 0 || ntx != 6 || nrx < 4) begin
            n_fail++; $display("FAIL loopback_valid_per_frame bad=%0d tx_rd=%0d rx_valid=%0d want 0/6/>=4", bad_cnt, ntx, nrx);
        end
    endtask

    task automatic test_random_stream();
        stereo_t sent[$];
        stereo_t p;
        int nrx = 0;
        ext_mode = 1'b0;
        tx_data_l = $urandom; tx_data_r = $urandom;
        reset_pulse();
        repeat (8 * FRAME_CYC) begin
            @(negedge clk);
            if (rx_valid) begin
                nrx++;
                n_checks++; if (sent.size() != 2) begin
                    n_fail++; $display("FAIL random_latency pending=%0d want 2", sent.size());
                end
                if (sent.size() > 0) begin
                    p = sent.pop_front();
                    n_checks++; if (rx_data_l !== p.l || rx_data_r !== p.r) begin
                        n_fail++; $display("FAIL random_data got %h/%h want %h/%h", rx_data_l, rx_data_r, p.l, p.r);
                    end
                end
            end
            if (tx_rd) begin
                p.l = tx_data_l; p.r = tx_data_r;
                sent.push_back(p);
                @(posedge clk);
                #1;
                tx_data_l = $urandom; tx_data_r = $urandom;
            end
        end
        n_checks++; if (nrx < 6) begin
            n_fail++; $display("FAIL random_rx_count got %0d want >=6", nrx);
        end
    endtask

`ifndef IIS_LOOPBACK_EN
    task automatic ext_slot(input logic w, input logic d);
        @(posedge clk); #1;
        ext_sck = 1'b0; ext_ws = w; ext_sd = d;
        repeat (3) @(posedge clk); #1;
        ext_sck = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_ext_16bit();
        logic [15:0] ls[3], rs[3];
        sample_t got_l[$], got_r[$];
        logic [31:0] bits;
        logic prev_bit = 1'b0;
        ls[0] = 16'h1234; rs[0] = 16'hFEDC;
        for (int f = 1; f < 3; f++) begin ls[f] = 16'($urandom); rs[f] = 16'($urandom); end
        ext_mode = 1'b1; ext_sck = 1'b0; ext_ws = 1'b1; ext_sd = 1'b0;
        reset_pulse();
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    bits = {ls[f], rs[f]};
                    for (int s = 0; s < 32; s++) begin
                        ext_slot(1'(s >= 16), prev_bit);
                        prev_bit = bits[31-s];
                    end
                end
                ext_slot(1'b0, prev_bit);
                ext_slot(1'b0, 1'b0);
            end
            begin
                repeat (700) begin
                    @(negedge clk);
                    if (rx_valid) begin got_l.push_back(rx_data_l); got_r.push_back(rx_data_r); end
                end
            end
        join
        n_checks++; if (got_l.size() != 3) begin
            n_fail++; $display("FAIL ext_valid_count got %0d want 3", got_l.size());
        end
        for (int f = 0; f < 3 && f < got_l.size(); f++) begin
            n_checks++; if (got_l[f] !== {ls[f], 16'h0} || got_r[f] !== {rs[f], 16'h0}) begin
                n_fail++; $display("FAIL ext_data frame %0d got %h/%h want %h0000/%h0000", f, got_l[f], got_r[f], ls[f], rs[f]);
            end
        end
        ext_mode = 1'b0;
    endtask
`endif

    task automatic test_midframe_reset();
        stereo_t sent[$];
        stereo_t p;
        int nrx = 0, spurious = 0;
        ext_mode = 1'b0;
        tx_data_l = $urandom | 1; tx_data_r = $urandom | 1;
        reset_pulse();
        repeat (2 * FRAME_CYC + 90) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (sck !== 1'b0 || ws !== 1'b1 || sd !== 1'b0 || tx_rd !== 1'b0) begin
            n_fail++; $display("FAIL midrst_pins got sck=%b ws=%b sd=%b tx_rd=%b want 0/1/0/0", sck, ws, sd, tx_rd);
        end
        n_checks++; if (rx_valid !== 1'b0 || rx_data_l !== '0 || rx_data_r !== '0) begin
            n_fail++; $display("FAIL midrst_rx got v=%b %h/%h want 0 0/0", rx_valid, rx_data_l, rx_data_r);
        end
        repeat (5) @(negedge clk);
        tx_data_l = $urandom; tx_data_r = $urandom;
        rst_n = 1'b1;
        repeat (4 * FRAME_CYC) begin
            @(negedge clk);
            if (rx_valid) begin
                nrx++;
                if (sent.size() != 2) spurious++;
                if (sent.size() > 0) begin
                    p = sent.pop_front();
                    n_checks++; if (rx_data_l !== p.l || rx_data_r !== p.r) begin
                        n_fail++; $display("FAIL midrst_data got %h/%h want %h/%h", rx_data_l, rx_data_r, p.l, p.r);
                    end
                end
            end
            if (tx_rd) begin
                p.l = tx_data_l; p.r = tx_data_r;
                sent.push_back(p);
                @(posedge clk);
                #1;
                tx_data_l = $urandom; tx_data_r = $urandom;
            end
        end
        n_checks++; if (spurious != 0 || nrx != 3) begin
            n_fail++; $display("FAIL midrst_valids spurious=%0d count=%0d want 0/3", spurious, nrx);
        end
    endtask

    initial begin
        test_reset();
        test_clock_timing();
        test_loopback_fixed();
        test_random_stream();
`ifndef IIS_LOOPBACK_EN
        test_ext_16bit();
`endif
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iis_serdes.md
# iis_serdes

Stereo I2S (Philips) serial link block: a master clock generator, a transmitter and a receiver in one unit on the system clock domain. It produces SCK/WS from the system clock, serialises one left/right sample pair per frame onto SD and requests the next pair. It independently deserialises an incoming I2S stream, which may come from a different master, into left/right words with a valid strobe. It sits between the audio datapath (parallel samples) and the codec pins.

## Interface

- SCK_DIV, 4, system-clock cycles per SCK period; even, ≥2. At 12.288 MHz this gives 3.072 MHz.
- FRAME_SCK, 64, SCK periods per WS frame; even, ≥4. With the defaults this gives 48 kHz.
- DATA_W, 32, bits per channel word; DATA_W ≤ FRAME_SCK/2.
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sck  out  1  generated bit clock.
- ws  out  1  generated word select; 0 = left, 1 = right.
- sd  out  1  transmit serial data.
- tx_data_l / tx_data_r  in  DATA_W  signed samples to transmit.
- tx_rd  out  1  one-clk pulse; tx words are captured in this cycle.
- rx_sck / rx_ws / rx_sd  in  1  receive pins, asynchronous to clk.
- rx_data_l / rx_data_r  out  DATA_W  received signed samples.
- rx_valid  out  1  one-clk pulse when a new rx pair is presented.

## Operation

- **Clock generation**
  - A divider counter runs 0..SCK_DIV-1.
  - sck=0 for counts 0..SCK_DIV/2-1 and sck=1 for the rest.
  - Internal sck_fall pulses in the clk cycle where sck goes 1→0.
  - The bit counter advances 0..FRAME_SCK-1 on each sck_fall and wraps to 0.
  - ws = (bit_cnt ≥ FRAME_SCK/2).
  - Internal f_sync = sck_fall AND the bit counter wraps to 0.
- **Transmitter**
  - Holds a 2·DATA_W shift register.
  - On every sck_fall: sd <= sreg MSB.
  - On f_sync: sreg <= {tx_data_l, tx_data_r} and tx_rd=1 that cycle.
  - On other sck_falls: sreg shifts left and shifts in 0.
  - Result: the left MSB appears one SCK after the ws falling edge, and the right LSB goes out coincident with the next ws fall (I2S one-bit delay).
  - If FRAME_SCK/2 > DATA_W, the unused trailing bits per channel are 0.
  - tx_data may change on any cycle except the tx_rd cycle.
- **Receiver**
  - rx_sck, rx_ws and rx_sd each pass through a 2-FF synchroniser.
  - A rising edge of synchronised sck is a sample event. At each event:
    - If the sampled ws differs from the previously sampled ws, the sd bit at this event is the LSB of the previous channel. Shift it in, then commit the word: ws went 1 means the left word is complete; ws went 0 means the right word is complete.
    - Otherwise, shift sd in while the per-channel bit count < DATA_W and ignore excess bits.
  - Words shorter than DATA_W are left-justified and zero-padded.
  - On a right-word commit, rx_data_l/rx_data_r update together and rx_valid pulses once.
  - No rx_valid is produced for the first frame after reset; at least one complete left half is required.
- **Reset values**
  - sck=0, ws=1, sd=0, tx_rd=0, rx_data_l=rx_data_r=0, rx_valid=0.
  - Divider=0, bit_cnt=FRAME_SCK-1, sreg=0, synchronisers=0.
  - The receiver's previous-ws flag is 1 and its word-started flag is 0.

## Timing

- The first sck_fall occurs SCK_DIV clk cycles after rst_n deasserts. It is an f_sync: ws→0 and tx_rd pulses.
- f_sync and tx_rd repeat every SCK_DIV·FRAME_SCK cycles (256 with the defaults). sd, ws and sck change in the same clk cycle.
- tx latency: the left MSB is on sd from the sck_fall after tx_rd. It is valid until the following sck_fall.
- rx latency: rx_valid asserts 4 clk cycles after the clk edge at which rx_sck is first high at its input pin. This is 2 synchroniser cycles, 1 edge-detect cycle and 1 output-register cycle.
- Reset mid-frame: all state returns immediately to its reset value. Partial rx words are discarded and no rx_valid is produced.

## Configuration

- IIS_LOOPBACK_EN defined: the receiver inputs are driven internally by sck/ws/sd and the rx_* pins are ignored.
- Undefined: the receiver uses the rx_* pins.

## Structure

- Package iis_pkg holds:
  - DATA_W default;
  - typedef sample_t (logic signed [DATA_W-1:0]);
  - typedef stereo_t (struct of l, r).
- Natural sub-module: iis_sck_gen, containing the divider, bit counter, ws, sck_fall and f_sync. The transmitter and receiver stay in the top.

## Test plan

- Reset then release → the first sck_fall and tx_rd occur 4 cycles later. The sck period is 4, ws toggles every 128 cycles, and tx_rd repeats every 256 cycles.
- Loopback build, tx_data_l=32'hA5A5_0001, tx_data_r=32'h8000_0000 → rx_data_l/r equal these values, with exactly one rx_valid per frame.
- tx_data driven with $random updated on tx_rd → the pair captured on each rx_valid matches the pair sent one frame earlier.
- External stream with 16 SCK per channel, L=16'h1234 → rx_data_l=32'h1234_0000.
- rst_n pulsed mid-frame → outputs return to reset values at once. No spurious rx_valid occurs, and the first full frame after release is received correctly.
